// File: rtl/mac_requant_if.sv
// rtl/mac_requant_if.sv - operand/result stream bundle for mac_requant; bias member present only with MAC_BIAS_EN
interface mac_requant_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_en;
  logic [7:0] out_data;
`ifdef MAC_BIAS_EN
  logic [7:0] bias;

  modport master (
    output in_valid, in_a, in_b, bias,
    input  in_ready, out_en, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, bias,
    output in_ready, out_en, out_data
  );
`else
  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, out_en, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, out_en, out_data
  );
`endif
endinterface

// File: rtl/mac_requant.sv
// rtl/mac_requant.sv - streaming int8 MAC over VEC_LEN pairs with round-half-up shift and int8 saturation
// Optional signed bias input enabled by defining MAC_BIAS_EN.
module mac_requant #(
  parameter int VEC_LEN = 4,
  parameter int SHIFT   = 4,
  parameter int ACC_W   = 20
) (
  input  logic         clk,
  input  logic         rst,
  mac_requant_if.slave bus
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

  typedef enum logic {ST_ACC, ST_EMIT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_en_q, out_en_d;
  logic                     in_ready;

  logic signed [15:0]       prod;
  logic signed [ACC_W:0]    bias_term;
  logic signed [ACC_W:0]    rq_sum;
  logic signed [ACC_W:0]    rq_shift;
  logic [7:0]               rq_sat;

  assign prod = $signed(bus.in_a) * $signed(bus.in_b);

  // Requantize in ACC_W+1 bits so the rounding/bias add can never wrap.
  always_comb begin
    bias_term = '0;
`ifdef MAC_BIAS_EN
    bias_term = {{(ACC_W-7){bus.bias[7]}}, bus.bias};
    bias_term = bias_term <<< SHIFT;
`endif
    rq_sum   = {acc_q[ACC_W-1], acc_q} + bias_term + RND;
    rq_shift = rq_sum >>> SHIFT;
    if (rq_shift > SAT_HI) begin
      rq_sat = 8'h7F;
    end else if (rq_shift < SAT_LO) begin
      rq_sat = 8'h80;
    end else begin
      rq_sat = rq_shift[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_en_d   = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        out_data_d = rq_sat;
        out_en_d   = 1'b1;
        acc_d      = '0;
        state_d    = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= 8'h00;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out_en   = out_en_q;
  assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_mac_requant.sv
// tb/tb_mac_requant.sv - directed vector bench for mac_requant (VEC_LEN=4, SHIFT=4, ACC_W=20)
module tb_mac_requant;

  logic clk;
  logic rst;

  mac_requant_if bus ();

  mac_requant #(
    .VEC_LEN(4),
    .SHIFT  (4),
    .ACC_W  (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    bit             gap;
    logic [7:0]     exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[12];

  function automatic vec_t mk(string name, int a0, int a1, int a2, int a3,
                              int b0, int b1, int b2, int b3, bit gap, int exp);
    vec_t v;
    v.name = name;
    v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
    v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
    v.gap  = gap;
    v.exp  = 8'(exp);
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h want 0x%02h", name, act, exp);
    end
  endtask

  // Present a pair and hold it until an edge accepts it; returns 1ns after that edge.
  task automatic send_beat(logic [7:0] a, logic [7:0] b);
    int  waited = 0;
    logic taken;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    forever begin
      taken = bus.in_ready;
      @(posedge clk); #1;
      if (taken) break;
      waited++;
      if (waited > 8) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no acceptance in %0d cycles want acceptance", waited);
        break;
      end
    end
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called 1ns after the edge accepting the last beat: EMIT now, pulse after next edge.
  task automatic expect_result(string name, logic [7:0] exp);
    check({name, "_emit_ready_en"}, {6'd0, bus.in_ready, bus.out_en}, 8'h00);
    @(posedge clk); #1;
    check({name, "_out_en"}, {7'd0, bus.out_en}, 8'h01);
    check({name, "_data"}, bus.out_data, exp);
    @(posedge clk); #1;
    check({name, "_pulse_end"}, {7'd0, bus.out_en}, 8'h00);
    check({name, "_data_hold"}, bus.out_data, exp);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
`ifdef MAC_BIAS_EN
    bus.bias     = 8'h00;
`endif

    vecs[0]  = mk("basic",   16, 16, 16, 16,    1, 1, 1, 1,         0, 8'h04);
    vecs[1]  = mk("pos_sat", 127, 127, 127, 127, 127, 127, 127, 127, 0, 8'h7F);
    vecs[2]  = mk("neg_sat", -128, -128, -128, -128, 127, 127, 127, 127, 0, 8'h80);
    vecs[3]  = mk("negneg",  -128, -128, -128, -128, -128, -128, -128, -128, 0, 8'h7F);
    vecs[4]  = mk("rnd_m3",  -3, 0, 0, 0,       1, 0, 0, 0,         0, 8'h00);
    vecs[5]  = mk("rnd_m9",  -9, 0, 0, 0,       1, 0, 0, 0,         0, 8'hFF);
    vecs[6]  = mk("rnd_p8",  8, 0, 0, 0,        1, 0, 0, 0,         0, 8'h01);
    vecs[7]  = mk("gaps",    16, 16, 16, 16,    1, 1, 1, 1,         1, 8'h04);
    vecs[8]  = mk("mixed",   100, -50, 7, 1,    -3, 2, 7, -1,       0, 8'hEA);
    vecs[9]  = mk("half_neg", -8, 0, 0, 0,      1, 0, 0, 0,         1, 8'h00);
    vecs[10] = mk("near_hi", 100, 8, 0, 0,      20, 1, 0, 0,        0, 8'h7E);
    vecs[11] = mk("near_lo", -100, -32, 0, 0,   20, 1, 0, 0,        1, 8'h81);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", {7'd0, bus.in_ready}, 8'h01);
    check("reset_out_en", {7'd0, bus.out_en}, 8'h00);
    check("reset_data", bus.out_data, 8'h00);

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 4; i++) begin
        send_beat(vecs[v].a[i], vecs[v].b[i]);
        if (vecs[v].gap && i < 3) idle(1);
      end
      bus.in_valid = 1'b0;
      expect_result(vecs[v].name, vecs[v].exp);
    end

    // Mid-vector reset discards the partial sum and clears the held result.
    send_beat(8'd10, 8'd10);
    send_beat(8'd10, 8'd10);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_data", bus.out_data, 8'h00);
    check("midrst_out_en", {7'd0, bus.out_en}, 8'h00);
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd16);
    bus.in_valid = 1'b0;
    expect_result("after_midrst", 8'h04);

    // Pair held through EMIT is taken once, as beat 1 of the next vector.
    for (int i = 0; i < 4; i++) send_beat(8'd16, 8'd1);
    bus.in_a = 8'd24;
    bus.in_b = 8'd1;
    expect_result("held_v1", 8'h04);
    for (int i = 0; i < 3; i++) send_beat(8'd0, 8'd0);
    bus.in_valid = 1'b0;
    expect_result("held_v2", 8'h02);

    // Reset landing on the EMIT edge cancels the pulse.
    for (int i = 0; i < 4; i++) send_beat(8'd16, 8'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("emitrst_out_en", {7'd0, bus.out_en}, 8'h00);
    check("emitrst_data", bus.out_data, 8'h00);
    check("emitrst_ready", {7'd0, bus.in_ready}, 8'h01);
    @(posedge clk); #1;
    check("emitrst_no_late_pulse", {7'd0, bus.out_en}, 8'h00);

`ifdef MAC_BIAS_EN
    bus.bias = 8'hFE;
    for (int i = 0; i < 4; i++) send_beat(8'd16, 8'd1);
    bus.in_valid = 1'b0;
    expect_result("bias_m2", 8'h02);
    bus.bias = 8'h00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Upstream producer for the ReLU activation stage: a streaming int8 multiply-accumulate unit.
- Accepts VEC_LEN signed 8-bit operand pairs and accumulates their products at full precision.
- Requantizes the sum to signed int8 by rounding right-shift and saturation.
- Presents the result on out_data with a one-cycle out_en pulse. out_data/out_en connect directly to the ReLU input_data/out_en.

Parameters:
- VEC_LEN, 4: products per output; must be >= 2.
- SHIFT, 4: requantization right-shift, range 0..15.
- ACC_W, 20: accumulator width (signed); must be >= 16 + clog2(VEC_LEN) + 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  8  signed operand A (two's complement).
- in_b  input  8  signed operand B (two's complement).
- out_en  output  1  one-cycle pulse: out_data updated with new result.
- out_data  output  8  signed int8 result; held between pulses.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high, sampled on the rising clk edge, and overrides all other activity.
- Reset values: state=ACC, beat count=0, acc=0, out_data=8'h00, out_en=0, in_ready=1 from the first cycle after reset.
- FSM has two states, ACC and EMIT.
- ACC state:
  - in_ready=1.
  - A beat is accepted on an edge where in_valid=1.
  - On acceptance: acc <= acc + sext(in_a*in_b) (signed 16-bit product, sign-extended to ACC_W).
  - On acceptance: count <= count+1.
  - in_valid=0: no change (gaps allowed anywhere).
- Leaving ACC: the beat that makes count reach VEC_LEN moves the FSM to EMIT and resets count to 0.
- EMIT state (exactly 1 cycle):
  - in_ready=0. in_valid is ignored; the upstream must hold its pair.
  - At the end-of-EMIT edge: out_data <= requant(acc), out_en <= 1, acc <= 0, state <= ACC.
- out_en falls to 0 on the next edge. out_data holds its value until the next EMIT.
- Latency: last beat accepted at edge k -> out_data/out_en valid after edge k+1.
- Throughput: one result per VEC_LEN+1 cycles at full input rate.
- requant(acc):
  - Extend acc to ACC_W+1 bits (no overflow on rounding).
  - If SHIFT>0, add 1<<(SHIFT-1) (round half up).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-128, 127].
- Reset mid-vector: partial acc and count are discarded. out_data returns to 0. A pending EMIT is cancelled with no out_en pulse.
- out_en is never asserted on two consecutive cycles.

Optional Feature:
- Macro MAC_BIAS_EN.
- When defined:
  - Adds input port bias (8 bit, signed), sampled in the EMIT cycle.
  - sext(bias) << SHIFT is added to acc before rounding, in the ACC_W+1 domain.
  - Saturation applies after the bias add.
- When undefined: no bias port; bias is effectively 0. Behaviour is otherwise identical.

Test Plan:
- Basic result: VEC_LEN=4, SHIFT=4, 4 beats a=16, b=1 back-to-back -> acc=64, (64+8)>>>4=4 -> out_data=8'h04, out_en high exactly 1 cycle, after edge k+1.
- Positive saturation: 4 beats a=127, b=127 -> acc=64516 -> 4032 -> out_data=8'h7F.
- Negative saturation: 4 beats a=-128, b=127 -> acc=-65024 -> out_data=8'h80. Also 4 beats a=-128, b=-128 -> acc=65536 with no accumulator overflow -> out_data=8'h7F.
- Rounding and sign:
  - beats (-3,1),(0,0),(0,0),(0,0) -> (-3+8)>>>4=0 -> 8'h00.
  - beats (-9,1),(0,0)x3 -> -1 -> 8'hFF.
  - beats (8,1),(0,0)x3 -> 1 -> 8'h01.
- Handshake and gaps:
  - in_valid toggles 1,0,1,0,... -> only valid cycles are counted; result matches the gap-free case.
  - A pair held valid during EMIT (in_ready=0) is not counted. It is accepted on the next cycle as beat 1 of the next vector.
- Reset mid-operation:
  - Accept 2 beats of (10,10), assert rst for 1 cycle -> out_data=0, no out_en.
  - Then 4 beats of (1,16) -> out_data=8'h04; the earlier partial sum does not appear.
- With MAC_BIAS_EN: bias=-2, 4 beats a=16, b=1 -> (64-32+8)>>>4=2 -> out_data=8'h02.
